// File: rtl/poly_arb_pkg.sv
// Shared types and helpers for the poly stream arbiter.
// Round-robin search and ID width sizing live here.
package poly_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_e;

  localparam int MAX_SRC = 8;

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // First set req bit after last, wrapping modulo n.
  function automatic logic [2:0] rr_next(
    input logic [MAX_SRC-1:0] req,
    input int                 last,
    input int                 n
  );
    logic [2:0] win;
    int         idx;
    win = '0;
    for (int i = MAX_SRC; i >= 1; i--) begin
      if (i <= n) begin
        idx = (last + i) % n;
        if (req[idx]) win = 3'(idx);
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/poly_stream_arbiter_if.sv
// Requester, core and return stream bundle.
// slave is the arbiter view, master the environment view.
interface poly_stream_arbiter_if #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_SRC*DATA_WIDTH-1:0] s_TDATA;
  logic [NUM_SRC-1:0]            s_TVALID;
  logic [NUM_SRC-1:0]            s_TREADY;
  logic [NUM_SRC-1:0]            s_TLAST;
  logic [DATA_WIDTH-1:0]         core_x_TDATA;
  logic                          core_x_TVALID;
  logic                          core_x_TREADY;
  logic                          core_x_TLAST;
  logic [DATA_WIDTH-1:0]         core_y_TDATA;
  logic                          core_y_TVALID;
  logic                          core_y_TREADY;
  logic                          core_y_TLAST;
  logic [NUM_SRC*DATA_WIDTH-1:0] m_TDATA;
  logic [NUM_SRC-1:0]            m_TVALID;
  logic [NUM_SRC-1:0]            m_TREADY;
  logic [NUM_SRC-1:0]            m_TLAST;
  logic                          busy;

  modport slave (
    input  s_TDATA, s_TVALID, s_TLAST,
    output s_TREADY,
    output core_x_TDATA, core_x_TVALID, core_x_TLAST,
    input  core_x_TREADY,
    input  core_y_TDATA, core_y_TVALID, core_y_TLAST,
    output core_y_TREADY,
    output m_TDATA, m_TVALID, m_TLAST,
    input  m_TREADY,
    output busy
  );

  modport master (
    output s_TDATA, s_TVALID, s_TLAST,
    input  s_TREADY,
    input  core_x_TDATA, core_x_TVALID, core_x_TLAST,
    output core_x_TREADY,
    output core_y_TDATA, core_y_TVALID, core_y_TLAST,
    input  core_y_TREADY,
    input  m_TDATA, m_TVALID, m_TLAST,
    output m_TREADY,
    input  busy
  );
endinterface

// File: rtl/poly_arb_id_fifo.sv
// In-order queue of granted source IDs awaiting core results.
module poly_arb_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (cnt_q == CW'(DEPTH));
    empty   = (cnt_q == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wr_d    = wr_q + PW'(do_push);
    rd_d    = rd_q + PW'(do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/poly_stream_arbiter.sv
// Round-robin packet arbiter sharing one poly core between
// NUM_SRC requesters, steering results back by queued source ID.
module poly_stream_arbiter
  import poly_arb_pkg::*;
#(
  parameter int NUM_SRC       = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  poly_stream_arbiter_if.slave bus
);
  localparam int ID_W = id_width(NUM_SRC);
  localparam int CW   = $clog2(ID_FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   winner, head;
  logic [MAX_SRC-1:0] req;
  logic              push, pop, full, empty, pass, x_fire, y_rdy;
  logic [CW-1:0]     count;
  logic [NUM_SRC-1:0] s_rdy, m_v, m_l;

  assign pass   = (state_q == PASS);
  assign x_fire = bus.core_x_TVALID & bus.core_x_TREADY;

  always_comb begin
    req = '0;
    req[NUM_SRC-1:0] = bus.s_TVALID;
    winner = ID_W'(rr_next(req, int'(last_q), NUM_SRC));
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: if (|bus.s_TVALID && !full) begin
        grant_d = winner;
        push    = 1'b1;
        state_d = PASS;
      end
      PASS: if (x_fire && bus.core_x_TLAST) begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    s_rdy = '0;
    if (pass) s_rdy[grant_q] = bus.core_x_TREADY;
  end

  assign bus.s_TREADY      = s_rdy;
  assign bus.core_x_TDATA  =
    bus.s_TDATA[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.core_x_TVALID = pass & bus.s_TVALID[grant_q];
  assign bus.core_x_TLAST  = pass & bus.s_TLAST[grant_q];

  // Return path follows the oldest in-flight ID only.
  always_comb begin
    m_v   = '0;
    m_l   = '0;
    y_rdy = 1'b0;
    if (!empty) begin
      m_v[head] = bus.core_y_TVALID;
      m_l[head] = bus.core_y_TLAST;
      y_rdy     = bus.m_TREADY[head];
    end
  end

  assign pop = bus.core_y_TVALID & y_rdy & bus.core_y_TLAST;

  assign bus.m_TVALID      = m_v;
  assign bus.m_TLAST       = m_l;
  assign bus.m_TDATA       = {NUM_SRC{bus.core_y_TDATA}};
  assign bus.core_y_TREADY = y_rdy;
  assign bus.busy          = pass | (count != '0);

  poly_arb_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (ID_FIFO_DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (grant_d),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
endmodule

// File: tb/tb_poly_stream_arbiter.sv
// Scoreboard bench: per-source queues model packet routing,
// a poly core model sits on the core side.
module tb_poly_stream_arbiter;
  localparam int NS  = 2;
  localparam int DW  = 32;
  localparam int DEP = 4;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  poly_stream_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus();

  poly_stream_arbiter #(
    .NUM_SRC       (NS),
    .DATA_WIDTH    (DW),
    .ID_FIFO_DEPTH (DEP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t srcq[NS][$];
  beat_t expm[NS][$];
  beat_t expx[$];
  beat_t coreq[$];
  int    x_time[$];
  int    vectors = 0;
  int    errs = 0;
  int    cyc = 0;
  int    x_cnt = 0;
  bit    x_check = 1;
  bit    rnd = 0;
  bit    m_rdy_force = 1;

  function automatic logic [31:0] poly(input logic [31:0] x);
    return x * x + 32'd2 * x + 32'd3;
  endfunction

  task automatic check(input string nm, input logic [32:0] act,
                       input logic [32:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_beat(input int s, input logic [31:0] d, input bit l);
    srcq[s].push_back('{d: d, l: l});
    expm[s].push_back('{d: poly(d), l: l});
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (srcq[i].size() > 0 && (!rnd || $urandom_range(3) != 0)) begin
        bus.s_TVALID[i] = 1'b1;
        bus.s_TDATA[i*DW +: DW] = srcq[i][0].d;
        bus.s_TLAST[i] = srcq[i][0].l;
      end else begin
        bus.s_TVALID[i] = 1'b0;
        bus.s_TLAST[i] = 1'b0;
      end
    end
    bus.core_x_TREADY = rnd ? 1'($urandom_range(1)) : 1'b1;
    if (coreq.size() > 0) begin
      bus.core_y_TVALID = 1'b1;
      bus.core_y_TDATA = coreq[0].d;
      bus.core_y_TLAST = coreq[0].l;
    end else begin
      bus.core_y_TVALID = 1'b0;
      bus.core_y_TLAST = 1'b0;
    end
    bus.m_TREADY = rnd ? NS'($urandom) : {NS{m_rdy_force}};
  endtask

  function automatic bit pending();
    bit p = (expx.size() > 0) || (coreq.size() > 0);
    for (int i = 0; i < NS; i++)
      if (srcq[i].size() > 0 || expm[i].size() > 0) p = 1;
    return p;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < NS; i++) begin
      srcq[i].delete();
      expm[i].delete();
    end
    expx.delete();
    coreq.delete();
    x_time.delete();
    x_cnt = 0;
    drive();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int maxc, input string nm);
    int n = 0;
    while (pending() && n < maxc) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= maxc) begin
      errs++;
      $display("FAIL %s drain: timeout after %0d cycles, required idle", nm, n);
    end
  endtask

  // Environment: sources, core model, sink readiness.
  initial begin
    logic [NS-1:0] sf;
    logic          xf, yf, xl;
    logic [31:0]   xd;
    bus.s_TDATA = '0;
    bus.s_TVALID = '0;
    bus.s_TLAST = '0;
    bus.core_x_TREADY = 1'b0;
    bus.core_y_TDATA = '0;
    bus.core_y_TVALID = 1'b0;
    bus.core_y_TLAST = 1'b0;
    bus.m_TREADY = '0;
    forever begin
      @(negedge clk);
      sf = bus.s_TVALID & bus.s_TREADY;
      xf = bus.core_x_TVALID & bus.core_x_TREADY;
      xd = bus.core_x_TDATA;
      xl = bus.core_x_TLAST;
      yf = bus.core_y_TVALID & bus.core_y_TREADY;
      if (xf && x_check && rst_n) begin
        if (expx.size() == 0) begin
          vectors++;
          errs++;
          $display("FAIL core_x order: got unexpected beat %0h, required none", xd);
        end else begin
          check("core_x beat", {xd, xl}, expx.pop_front());
        end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n) begin
        for (int i = 0; i < NS; i++)
          if (sf[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (xf) begin
          coreq.push_back('{d: poly(xd), l: xl});
          x_cnt++;
          x_time.push_back(cyc);
        end
        if (yf && coreq.size() > 0) void'(coreq.pop_front());
        drive();
      end
    end
  end

  // Result monitor against per-source expected queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < NS; i++) begin
          if (bus.m_TVALID[i] && bus.m_TREADY[i]) begin
            if (expm[i].size() == 0) begin
              vectors++;
              errs++;
              $display("FAIL m port %0d: got unexpected beat %0h, required none",
                       i, bus.m_TDATA[i*DW +: DW]);
            end else begin
              check($sformatf("m port %0d", i),
                    {bus.m_TDATA[i*DW +: DW], bus.m_TLAST[i]},
                    expm[i].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] v;
    rst_n = 1'b0;
    #3;
    check("reset s_TREADY", 33'(bus.s_TREADY), 33'd0);
    check("reset core_x_TVALID", 33'(bus.core_x_TVALID), 33'd0);
    check("reset core_y_TREADY", 33'(bus.core_y_TREADY), 33'd0);
    check("reset m_TVALID", 33'(bus.m_TVALID), 33'd0);
    check("reset busy", 33'(bus.busy), 33'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Single source, 3-beat packet.
    add_beat(0, 1, 0); add_beat(0, 2, 0); add_beat(0, 3, 1);
    expx.push_back('{d: 1, l: 0});
    expx.push_back('{d: 2, l: 0});
    expx.push_back('{d: 3, l: 1});
    wait_drain(100, "t1");
    check("t1 x beats", 33'(x_cnt), 33'd3);

    // Two contending 2-beat packets.
    do_reset();
    add_beat(0, 4, 0); add_beat(0, 5, 1);
    add_beat(1, 7, 0); add_beat(1, 8, 1);
    expx.push_back('{d: 4, l: 0});
    expx.push_back('{d: 5, l: 1});
    expx.push_back('{d: 7, l: 0});
    expx.push_back('{d: 8, l: 1});
    wait_drain(100, "t2");
    if (x_time.size() == 4) begin
      check("t2 in-packet spacing", 33'(x_time[1] - x_time[0]), 33'd1);
      check("t2 idle gap", 33'(x_time[2] - x_time[1]), 33'd2);
    end else begin
      check("t2 x beats", 33'(x_time.size()), 33'd4);
    end

    // Alternating 1-beat grants.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < NS; s++) begin
        v = 32'($urandom_range(1000));
        add_beat(s, v, 1);
        expx.push_back('{d: v, l: 1});
      end
    end
    for (int k = 0; k < 3; k++) begin
      beat_t b0, b1;
      b0 = srcq[0][k];
      b1 = srcq[1][k];
      expx.push_back(b0);
      expx.push_back(b1);
    end
    repeat (6) void'(expx.pop_front());
    wait_drain(200, "t3");
    check("t3 x beats", 33'(x_cnt), 33'd6);

    // ID FIFO full back-pressure.
    do_reset();
    m_rdy_force = 0;
    for (int k = 0; k < 5; k++) begin
      add_beat(0, 32'(20 + k), 1);
      expx.push_back('{d: 32'(20 + k), l: 1});
    end
    repeat (20) @(negedge clk);
    check("t4 grants when full", 33'(x_cnt), 33'd4);
    check("t4 s_TREADY when full", 33'(bus.s_TREADY), 33'd0);
    check("t4 core_x_TVALID when full", 33'(bus.core_x_TVALID), 33'd0);
    check("t4 busy when full", 33'(bus.busy), 33'd1);
    m_rdy_force = 1;
    n = 0;
    while (x_cnt < 5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4 fifth grant", 33'(x_cnt), 33'd5);
    wait_drain(100, "t4");

    // Asynchronous reset mid-packet.
    do_reset();
    x_check = 0;
    add_beat(0, 10, 0); add_beat(0, 11, 0);
    add_beat(0, 12, 0); add_beat(0, 13, 1);
    n = 0;
    while (x_cnt < 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("t5 mid-packet valid", 33'(bus.core_x_TVALID), 33'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5 s_TREADY", 33'(bus.s_TREADY), 33'd0);
    check("t5 core_x_TVALID", 33'(bus.core_x_TVALID), 33'd0);
    check("t5 m_TVALID", 33'(bus.m_TVALID), 33'd0);
    check("t5 busy", 33'(bus.busy), 33'd0);
    clear_all();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    x_check = 1;
    add_beat(0, 30, 1);
    add_beat(1, 31, 1);
    expx.push_back('{d: 30, l: 1});
    expx.push_back('{d: 31, l: 1});
    wait_drain(100, "t5");

    // Randomized traffic and back-pressure.
    do_reset();
    x_check = 0;
    rnd = 1;
    for (int p = 0; p < 40; p++) begin
      int s, len;
      s = $urandom_range(NS - 1);
      len = $urandom_range(4, 1);
      for (int b = 0; b < len; b++)
        add_beat(s, 32'($urandom), b == len - 1);
    end
    wait_drain(5000, "random");
    rnd = 0;
    repeat (3) @(negedge clk);
    check("final busy", 33'(bus.busy), 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
